gobou_core_ctrl: RTL and testbench

- Sequencer that drives the control strobes of the gobou MAC/bias/ReLU datapath core for one fully-connected layer.
- It walks output neurons and input pixels, issues pixel and weight memory read addresses, and times the core's accumulate, bias, ReLU and output-enable strobes against 1-cycle memory read latency.
- It signals a write-back strobe when each neuron result is valid.
- It sits between the layer-level controller (req/ack) and the core plus the input, weight and output buffers.

---
 rtl/gobou_core_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_gobou_core_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gobou_core_ctrl.sv
// gobou_core_ctrl: per-layer sequencer for the gobou MAC/bias/ReLU core.
// Walks neurons and input pixels, issues pixel and weight read addresses, and
// times the core strobes against the one-cycle buffer read latency.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for req (also parks here during the single ack cycle)
// BIAS  | c0 of a neuron: bias word address out, accumulator cleared
// ACC   | c1..cN: pixel/weight addresses stream, products accumulate
// DRAIN | cN+1..cN+4: last accumulate, then mac/bias/relu output stages
//
// Every output is registered. The combinational output block computes the
// value each output must carry in the *next* cycle from the next-state
// values, so the strobes line up with the cycle numbering without extra lag.

module gobou_core_ctrl #(
  parameter int DWIDTHLOG = 4,
  parameter int IWIDTH    = 12,
  parameter int OWIDTH    = 10,
  parameter int WWIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 req,
  input  logic [IWIDTH-1:0]    n_in,
  input  logic [OWIDTH-1:0]    n_out,
  input  logic [DWIDTHLOG-1:0] qbits,
  input  logic                 bias_en,
  input  logic                 relu_en,
  output logic                 busy,
  output logic                 ack,
  output logic [IWIDTH-1:0]    in_addr,
  output logic [WWIDTH-1:0]    w_addr,
  output logic [OWIDTH-1:0]    out_addr,
  output logic                 out_we,
  output logic                 accum_rst,
  output logic                 accum_we,
  output logic                 mac_oe,
  output logic                 breg_we,
  output logic                 bias_oe,
  output logic                 relu_oe,
  output logic [DWIDTHLOG-1:0] _qbits,
  output logic                 _bias_en,
  output logic                 _relu_en
);

  // Cycle-in-neuron counter must reach n_in+4, hence one extra bit.
  localparam int CWIDTH = IWIDTH + 1;
  localparam int KWIDTH = OWIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BIAS  = 2'd1,
    S_ACC   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [CWIDTH-1:0] cyc, cyc_nx;
  logic [OWIDTH-1:0] k, k_nx;

  logic [IWIDTH-1:0] n_in_l;
  logic [OWIDTH-1:0] n_out_l;

  logic              accept;
  logic              degen;
  logic              acc_end;
  logic              drain_end;
  logic              last_neuron;
  logic [CWIDTH-1:0] n_in_c;
  logic [CWIDTH-1:0] drain_tc;
  logic [KWIDTH-1:0] k_inc;

  logic              busy_nx;
  logic              ack_nx;
  logic [IWIDTH-1:0] in_addr_nx;
  logic [WWIDTH-1:0] w_addr_nx;
  logic [OWIDTH-1:0] out_addr_nx;
  logic              out_we_nx;
  logic              accum_rst_nx;
  logic              accum_we_nx;
  logic              mac_oe_nx;
  logic              breg_we_nx;
  logic              bias_oe_nx;
  logic              relu_oe_nx;

  // The ack cycle is spent in IDLE, so ack itself blocks acceptance there.
  assign accept      = (state == S_IDLE) && req && !ack;
  assign degen       = (n_in == '0) || (n_out == '0);
  assign n_in_c      = CWIDTH'(n_in_l);
  assign drain_tc    = n_in_c + CWIDTH'(4);
  assign acc_end     = cyc >= n_in_c;
  assign drain_end   = cyc >= drain_tc;
  assign k_inc       = KWIDTH'(k) + KWIDTH'(1);
  assign last_neuron = k_inc >= KWIDTH'(n_out_l);

  // State, cycle and neuron registers
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state <= S_IDLE;
      cyc   <= '0;
      k     <= '0;
    end else begin
      state <= state_nx;
      cyc   <= cyc_nx;
      k     <= k_nx;
    end
  end

  // Layer configuration captured on an accepted req
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      n_in_l   <= '0;
      n_out_l  <= '0;
      _qbits   <= '0;
      _bias_en <= 1'b0;
      _relu_en <= 1'b0;
    end else if (accept) begin
      n_in_l   <= n_in;
      n_out_l  <= n_out;
      _qbits   <= qbits;
      _bias_en <= bias_en;
      _relu_en <= relu_en;
    end
  end

  // Next-state: BIAS -> ACC x n_in -> DRAIN x 4 -> next BIAS or IDLE
  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    k_nx     = k;
    case (state)
      S_IDLE: begin
        if (accept && !degen) begin
          state_nx = S_BIAS;
          cyc_nx   = '0;
          k_nx     = '0;
        end
      end
      S_BIAS: begin
        state_nx = S_ACC;
        cyc_nx   = cyc + CWIDTH'(1);
      end
      S_ACC: begin
        cyc_nx = cyc + CWIDTH'(1);
        if (acc_end) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          cyc_nx = '0;
          if (last_neuron) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_BIAS;
            k_nx     = k + OWIDTH'(1);
          end
        end else begin
          cyc_nx = cyc + CWIDTH'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cyc_nx   = '0;
        k_nx     = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next-state values
  always_comb begin
    accum_rst_nx = (state_nx == S_BIAS);
    breg_we_nx   = (state_nx == S_ACC) && (cyc_nx == CWIDTH'(1));
    // Weight data lags its address by one cycle, so accumulation spills one
    // cycle into DRAIN.
    accum_we_nx  = ((state_nx == S_ACC) && (cyc_nx >= CWIDTH'(2))) ||
                   ((state_nx == S_DRAIN) && (cyc_nx == n_in_c + CWIDTH'(1)));
    mac_oe_nx    = (state_nx == S_DRAIN) && (cyc_nx == n_in_c + CWIDTH'(2));
    bias_oe_nx   = (state_nx == S_DRAIN) && (cyc_nx == n_in_c + CWIDTH'(3));
    relu_oe_nx   = (state_nx == S_DRAIN) && (cyc_nx == n_in_c + CWIDTH'(4));

    in_addr_nx   = '0;
    if (state_nx == S_ACC) begin
      in_addr_nx = IWIDTH'(cyc_nx - CWIDTH'(1));
    end

    // Weight blocks are contiguous (bias word then n_in weights), so the
    // address just keeps counting from one neuron into the next.
    w_addr_nx = w_addr;
    if (accept) begin
      w_addr_nx = '0;
    end else if ((state_nx == S_ACC) ||
                 ((state == S_DRAIN) && (state_nx == S_BIAS))) begin
      w_addr_nx = w_addr + WWIDTH'(1);
    end

    // Write-back of neuron k lands in cN+5, overlapping the next BIAS cycle.
    out_we_nx   = (state == S_DRAIN) && drain_end;
    out_addr_nx = out_we_nx ? k : out_addr;

    ack_nx  = (accept && degen) ||
              ((state == S_DRAIN) && drain_end && last_neuron);

    busy_nx = busy;
    if (accept) begin
      busy_nx = 1'b1;
    end else if (ack) begin
      busy_nx = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      busy      <= 1'b0;
      ack       <= 1'b0;
      in_addr   <= '0;
      w_addr    <= '0;
      out_addr  <= '0;
      out_we    <= 1'b0;
      accum_rst <= 1'b0;
      accum_we  <= 1'b0;
      mac_oe    <= 1'b0;
      breg_we   <= 1'b0;
      bias_oe   <= 1'b0;
      relu_oe   <= 1'b0;
    end else begin
      busy      <= busy_nx;
      ack       <= ack_nx;
      in_addr   <= in_addr_nx;
      w_addr    <= w_addr_nx;
      out_addr  <= out_addr_nx;
      out_we    <= out_we_nx;
      accum_rst <= accum_rst_nx;
      accum_we  <= accum_we_nx;
      mac_oe    <= mac_oe_nx;
      breg_we   <= breg_we_nx;
      bias_oe   <= bias_oe_nx;
      relu_oe   <= relu_oe_nx;
    end
  end

endmodule

// File: tb/tb_gobou_core_ctrl.sv
// Directed bench for gobou_core_ctrl; expected strobe patterns are
// hand-derived per-cycle bit masks indexed by cycle offset from c0.

module tb_gobou_core_ctrl;

  logic        clk;
  logic        xrst;
  logic        req;
  logic [11:0] n_in;
  logic [9:0]  n_out;
  logic [3:0]  qbits;
  logic        bias_en;
  logic        relu_en;
  logic        busy;
  logic        ack;
  logic [11:0] in_addr;
  logic [15:0] w_addr;
  logic [9:0]  out_addr;
  logic        out_we;
  logic        accum_rst;
  logic        accum_we;
  logic        mac_oe;
  logic        breg_we;
  logic        bias_oe;
  logic        relu_oe;
  logic [3:0]  l_qbits;
  logic        l_bias_en;
  logic        l_relu_en;

  int checks = 0;
  int errors = 0;

  // per-cycle expectation masks (bit c = value in cycle c)
  logic [63:0] m_rst, m_breg, m_acc, m_mac, m_bias, m_relu, m_we, m_ack, m_busy;

  gobou_core_ctrl dut (
    .clk       (clk),
    .xrst      (xrst),
    .req       (req),
    .n_in      (n_in),
    .n_out     (n_out),
    .qbits     (qbits),
    .bias_en   (bias_en),
    .relu_en   (relu_en),
    .busy      (busy),
    .ack       (ack),
    .in_addr   (in_addr),
    .w_addr    (w_addr),
    .out_addr  (out_addr),
    .out_we    (out_we),
    .accum_rst (accum_rst),
    .accum_we  (accum_we),
    .mac_oe    (mac_oe),
    .breg_we   (breg_we),
    .bias_oe   (bias_oe),
    .relu_oe   (relu_oe),
    ._qbits    (l_qbits),
    ._bias_en  (l_bias_en),
    ._relu_en  (l_relu_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] strobes();
    return {out_we, ack, busy, accum_rst, breg_we, accum_we, mac_oe, bias_oe, relu_oe};
  endfunction

  function automatic logic [8:0] exp_strobes(input int c);
    return {m_we[c], m_ack[c], m_busy[c], m_rst[c], m_breg[c], m_acc[c],
            m_mac[c], m_bias[c], m_relu[c]};
  endfunction

  function automatic logic [63:0] all_outs();
    return {11'd0, busy, ack, in_addr, w_addr, out_addr, out_we, accum_rst, accum_we,
            mac_oe, breg_we, bias_oe, relu_oe, l_qbits, l_bias_en, l_relu_en};
  endfunction

  task automatic start(input int ni, input int no, input int qb, input logic be, input logic re);
    n_in = 12'(ni); n_out = 10'(no); qbits = 4'(qb); bias_en = be; relu_en = re;
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy && !ack) break;
      step();
    end
    chk(tag, {62'd0, busy, ack}, 64'd0);
    step();
  endtask

  initial begin
    int ack_cnt;
    int max_in;
    int we_cyc;
    int ack_cyc;
    int we_addr;

    xrst = 1'b1; req = 1'b0; n_in = '0; n_out = '0; qbits = '0;
    bias_en = 1'b0; relu_en = 1'b0;
    step(); step();
    chk("reset_outputs", all_outs(), 64'd0);
    xrst = 1'b0;
    step();
    chk("idle_outputs", all_outs(), 64'd0);

    // ---- n_in=3, n_out=2, with ignored reqs at c4 and c16, restart at c17
    m_rst  = 64'h40101;  m_breg = 64'h202;    m_acc  = 64'h1C1C;
    m_mac  = 64'h2020;   m_bias = 64'h4040;   m_relu = 64'h8080;
    m_we   = 64'h10100;  m_ack  = 64'h10000;  m_busy = 64'h5FFFF;
    start(3, 2, 3, 1'b1, 1'b0);
    for (int c = 0; c <= 18; c++) begin
      chk($sformatf("t1_strobes_c%0d", c), 64'(strobes()), 64'(exp_strobes(c)));
      if (c <= 3)             chk($sformatf("t1_waddr_c%0d", c), 64'(w_addr), 64'(c));
      if (c >= 8 && c <= 11)  chk($sformatf("t1_waddr_c%0d", c), 64'(w_addr), 64'(c - 4));
      if (c >= 1 && c <= 3)   chk($sformatf("t1_inaddr_c%0d", c), 64'(in_addr), 64'(c - 1));
      if (c >= 9 && c <= 11)  chk($sformatf("t1_inaddr_c%0d", c), 64'(in_addr), 64'(c - 9));
      if (c == 8)  chk("t1_outaddr_c8", 64'(out_addr), 64'd0);
      if (c == 16) chk("t1_outaddr_c16", 64'(out_addr), 64'd1);
      if (c == 1)  chk("t1_latched", 64'({l_qbits, l_bias_en, l_relu_en}), 64'({4'd3, 1'b1, 1'b0}));
      if (c == 10) chk("t1_latched_hold", 64'({l_qbits, l_bias_en, l_relu_en}), 64'({4'd3, 1'b1, 1'b0}));
      if (c == 18) begin
        chk("t1_relatch", 64'({l_qbits, l_bias_en, l_relu_en}), 64'({4'd5, 1'b0, 1'b1}));
        chk("t1_restart_waddr", 64'(w_addr), 64'd0);
      end
      req = 1'b0;
      if (c == 4)  begin req = 1'b1; n_out = 10'd0; qbits = 4'd9; end
      if (c == 16) begin req = 1'b1; n_in = 12'd0; qbits = 4'd9; end
      if (c == 17) begin
        req = 1'b1; n_in = 12'd1; n_out = 10'd1; qbits = 4'd5;
        bias_en = 1'b0; relu_en = 1'b1;
      end
      step();
    end
    req = 1'b0;
    wait_idle("t1_idle", 40);

    // ---- n_in=1, n_out=3: 6-cycle neuron period
    m_rst  = 64'h1041;   m_breg = 64'h2082;   m_acc  = 64'h4104;
    m_mac  = 64'h8208;   m_bias = 64'h10410;  m_relu = 64'h20820;
    m_we   = 64'h41040;  m_ack  = 64'h40000;  m_busy = 64'h7FFFF;
    start(1, 3, 2, 1'b1, 1'b1);
    for (int c = 0; c <= 19; c++) begin
      chk($sformatf("t2_strobes_c%0d", c), 64'(strobes()), 64'(exp_strobes(c)));
      if (c == 6 || c == 12 || c == 18)
        chk($sformatf("t2_outaddr_c%0d", c), 64'(out_addr), 64'((c / 6) - 1));
      if (c == 7) chk("t2_waddr_c7", 64'(w_addr), 64'd3);
      step();
    end

    // ---- degenerate configs: ack one cycle after req, no strobes
    start(2, 0, 1, 1'b0, 1'b0);
    chk("dg_nout0_c0", 64'(strobes()), 64'(9'b011000000));
    step();
    chk("dg_nout0_c1", 64'(strobes()), 64'd0);
    step();
    start(0, 2, 1, 1'b0, 1'b0);
    chk("dg_nin0_c0", 64'(strobes()), 64'(9'b011000000));
    step();
    chk("dg_nin0_c1", 64'(strobes()), 64'd0);
    step();

    // ---- async reset mid-run aborts without ack
    start(3, 2, 7, 1'b1, 1'b1);
    step(); step(); step();
    chk("rs_c3_accum_we", 64'(accum_we), 64'd1);
    xrst = 1'b1;
    #1;
    chk("rs_async_zero", all_outs(), 64'd0);
    step();
    xrst = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ack) ack_cnt++;
      step();
    end
    chk("rs_no_ack", 64'(ack_cnt), 64'd0);
    start(2, 1, 1, 1'b0, 1'b0);
    chk("rs_restart", 64'({busy, accum_rst, w_addr}), 64'({1'b1, 1'b1, 16'd0}));
    wait_idle("rs_idle", 20);

    // ---- maximum n_in
    max_in = 0; we_cyc = -1; ack_cyc = -1; we_addr = -1;
    start(4095, 1, 0, 1'b0, 1'b0);
    for (int c = 0; c <= 4104; c++) begin
      if (int'(in_addr) > max_in) max_in = int'(in_addr);
      if (c == 4095) chk("mx_inaddr_c4095", 64'(in_addr), 64'd4094);
      if (c == 4095) chk("mx_waddr_c4095", 64'(w_addr), 64'd4095);
      if (out_we && we_cyc < 0) begin we_cyc = c; we_addr = int'(out_addr); end
      if (ack && ack_cyc < 0) ack_cyc = c;
      step();
    end
    chk("mx_max_inaddr", 64'(max_in), 64'd4094);
    chk("mx_out_we_cycle", 64'(we_cyc), 64'd4100);
    chk("mx_out_addr", 64'(we_addr), 64'd0);
    chk("mx_ack_cycle", 64'(ack_cyc), 64'd4100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
